fpu_sequencer: RTL

//  Shares one combinational fpu datapath between two requesters (req0, req1).

---
 rtl/pa_fpu.sv | 38 +++
 rtl/fpu_datapath.sv | 115 +++++++++++
 rtl/fpu_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pa_fpu.sv
// Shared FPU package: op codes, sequencer states, status flags and helpers.
// Used by the fpu datapath and by fpu_sequencer.
package pa_fpu;

  typedef enum logic [1:0] {
    op_add,
    op_sub,
    op_mul,
    op_div
  } e_fpu_op;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } e_fpu_seq_state;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic subnormal;
  } st_fpu_flags;

  localparam logic [7:0]  FPU_EXP_MAX = 8'hFF;
  localparam logic [31:0] FPU_QNAN    = 32'h7fc00000;

  // Sign bit is irrelevant to the class, so only exp+man are taken.
  function automatic st_fpu_flags fpu_classify(input logic [30:0] v);
    st_fpu_flags f;
    f.nan       = (v[30:23] == FPU_EXP_MAX) && (v[22:0] != '0);
    f.inf       = (v[30:23] == FPU_EXP_MAX) && (v[22:0] == '0);
    f.zero      = (v[30:23] == 8'd0) && (v[22:0] == '0);
    f.subnormal = (v[30:23] == 8'd0) && (v[22:0] != '0);
    return f;
  endfunction

endpackage

// File: rtl/fpu_datapath.sv
// Combinational IEEE-754 single datapath (add/sub/mul/div, truncating).
// Ports: a_i, b_i operands; op_i operation; result_o packed result.
module fpu_datapath
  import pa_fpu::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  e_fpu_op     op_i,
  output logic [31:0] result_o
);

  // Pack m * 2^x, truncating towards zero; handles overflow and subnormals.
  function automatic logic [31:0] pack(
    input logic        s,
    input logic [63:0] m,
    input int          x
  );
    int p;
    int be;
    int sh;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    be = p + x + 127;
    if (m == 64'd0) begin
      pack = {s, 31'd0};
    end else if (be >= 255) begin
      pack = {s, FPU_EXP_MAX, 23'd0};
    end else if (be >= 1) begin
      sh = p - 23;
      pack = {s, 8'(be), 23'(sh >= 0 ? m >> sh : m << -sh)};
    end else begin
      sh = -(x + 149);
      pack = {s, 8'd0, 23'(sh >= 0 ? m >> sh : m << -sh)};
    end
  endfunction

  logic        sa, sb, sbe, sx;
  logic [7:0]  ea_r, eb_r;
  logic [23:0] ma, mb;
  int          ea, eb;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

  assign sa   = a_i[31];
  assign sb   = b_i[31];
  assign sbe  = (op_i == op_sub) ? ~sb : sb;
  assign sx   = sa ^ sb;
  assign ea_r = a_i[30:23];
  assign eb_r = b_i[30:23];
  assign ma   = {ea_r != 8'd0, a_i[22:0]};
  assign mb   = {eb_r != 8'd0, b_i[22:0]};
  // Subnormals share the minimum exponent without a hidden bit.
  assign ea   = (ea_r == 8'd0) ? 1 : int'(ea_r);
  assign eb   = (eb_r == 8'd0) ? 1 : int'(eb_r);

  assign nan_a  = (ea_r == FPU_EXP_MAX) && (a_i[22:0] != '0);
  assign nan_b  = (eb_r == FPU_EXP_MAX) && (b_i[22:0] != '0);
  assign inf_a  = (ea_r == FPU_EXP_MAX) && (a_i[22:0] == '0);
  assign inf_b  = (eb_r == FPU_EXP_MAX) && (b_i[22:0] == '0);
  assign zero_a = (ea_r == 8'd0) && (a_i[22:0] == '0);
  assign zero_b = (eb_r == 8'd0) && (b_i[22:0] == '0);

  int          d, x;
  logic [63:0] am, bm;

  always_comb begin
    result_o = FPU_QNAN;
    d  = 0;
    x  = 0;
    am = '0;
    bm = '0;
    unique case (op_i)
      op_add, op_sub: begin
        if (ea >= eb) begin
          d  = ea - eb;
          x  = eb - 150;
          am = {40'd0, ma} << d;
          bm = {40'd0, mb};
        end else begin
          d  = eb - ea;
          x  = ea - 150;
          am = {40'd0, ma};
          bm = {40'd0, mb} << d;
        end
        if (nan_a || nan_b) result_o = FPU_QNAN;
        else if (inf_a && inf_b && (sa != sbe)) result_o = FPU_QNAN;
        else if (inf_a) result_o = {sa, FPU_EXP_MAX, 23'd0};
        else if (inf_b) result_o = {sbe, FPU_EXP_MAX, 23'd0};
        // Too far apart to align in 64 bits: the small addend is dropped.
        else if (d > 38) begin
          if (ea >= eb) result_o = pack(sa, {40'd0, ma}, ea - 150);
          else          result_o = pack(sbe, {40'd0, mb}, eb - 150);
        end
        else if (sa == sbe) result_o = pack(sa, am + bm, x);
        else if (am >= bm)  result_o = pack(sa & (am != bm), am - bm, x);
        else                result_o = pack(sbe, bm - am, x);
      end
      op_mul: begin
        if (nan_a || nan_b) result_o = FPU_QNAN;
        else if ((inf_a && zero_b) || (zero_a && inf_b)) result_o = FPU_QNAN;
        else if (inf_a || inf_b) result_o = {sx, FPU_EXP_MAX, 23'd0};
        else result_o = pack(sx, {40'd0, ma} * {40'd0, mb}, ea + eb - 300);
      end
      op_div: begin
        if (nan_a || nan_b) result_o = FPU_QNAN;
        else if ((inf_a && inf_b) || (zero_a && zero_b)) result_o = FPU_QNAN;
        else if (inf_a || zero_b) result_o = {sx, FPU_EXP_MAX, 23'd0};
        else if (inf_b || zero_a) result_o = {sx, 31'd0};
        else result_o = pack(sx, ({40'd0, ma} << 39) / {40'd0, mb},
                             ea - eb - 39);
      end
      default: result_o = FPU_QNAN;
    endcase
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Round-robin sequencer sharing one fpu_datapath between two requesters.
// Ports: clk, rst (sync, high); req0_*/req1_* valid/ready/a/b/op requests;
// resp_valid/ready/id/result/flags response; busy; op_count (wraps).
// Option FPU_STATUS_FLAGS_EN: register {nan,inf,zero,subnormal} with result.
module fpu_sequencer
  import pa_fpu::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int MUL_EXTRA     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  e_fpu_op     req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  e_fpu_op     req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic [3:0]  resp_flags,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam int CNT_MAX = SETTLE_CYCLES - 1 + MUL_EXTRA;
  localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("fpu_sequencer: SETTLE_CYCLES must be >= 1");
  end

  e_fpu_seq_state state_q, state_d;
  logic           last_q, last_d;
  logic           id_q, id_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  e_fpu_op        op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           rid_q, rid_d;
  logic [31:0]    res_q, res_d;
  logic [15:0]    op_count_q, op_count_d;
  logic [31:0]    fpu_res;
  logic           gnt0, gnt1;
  e_fpu_op        gnt_op;

  fpu_datapath u_fpu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (fpu_res)
  );

  // On a tie the requester not served last wins; last_q resets to 1.
  assign gnt0   = req0_valid & (~req1_valid | last_q);
  assign gnt1   = req1_valid & (~req0_valid | ~last_q);
  assign gnt_op = gnt1 ? req1_op : req0_op;

`ifdef FPU_STATUS_FLAGS_EN
  st_fpu_flags flags_q, flags_d;
  assign resp_flags = flags_q;
`else
  assign resp_flags = 4'b0000;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    rid_d      = rid_q;
    res_d      = res_q;
    op_count_d = op_count_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
`ifdef FPU_STATUS_FLAGS_EN
    flags_d    = flags_q;
`endif
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 | gnt1) begin
          id_d    = gnt1;
          last_d  = gnt1;
          a_d     = gnt1 ? req1_a : req0_a;
          b_d     = gnt1 ? req1_b : req0_b;
          op_d    = gnt_op;
          cnt_d   = CW'(SETTLE_CYCLES - 1)
                  + ((gnt_op == op_mul) ? CW'(MUL_EXTRA) : CW'(0));
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          res_d   = fpu_res;
          rid_d   = id_q;
          valid_d = 1'b1;
          state_d = DONE;
`ifdef FPU_STATUS_FLAGS_EN
          flags_d = fpu_classify(fpu_res[30:0]);
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          valid_d    = 1'b0;
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= op_add;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      rid_q      <= 1'b0;
      res_q      <= '0;
      op_count_q <= '0;
`ifdef FPU_STATUS_FLAGS_EN
      flags_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      rid_q      <= rid_d;
      res_q      <= res_d;
      op_count_q <= op_count_d;
`ifdef FPU_STATUS_FLAGS_EN
      flags_q    <= flags_d;
`endif
    end
  end

  assign resp_valid  = valid_q;
  assign resp_id     = rid_q;
  assign resp_result = res_q;
  assign busy        = (state_q != IDLE);
  assign op_count    = op_count_q;

endmodule
